// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the fetch / load-store memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arbState_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LS    = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_TIMEOUT_WIDTH  = 8;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts BUSY cycles without a memory response; flags the last allowed cycle.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic CoreClock,
    input  logic CoreResetN,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [TIMEOUT_WIDTH-1:0] waitCount;

    always_ff @(posedge CoreClock) begin
        if (!CoreResetN || clear) begin
            waitCount <= '0;
        end else if (enable) begin
            waitCount <= waitCount + TIMEOUT_WIDTH'(1);
        end
    end

    // Count starts at 0 on entry, so the Nth waiting cycle sees N-1.
    assign expired_c = enable && (waitCount == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and
// load/store; one transaction at a time, word addressing, bounded by a timeout.
module memory_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                  CoreClock,
    input  logic                  CoreResetN,
    input  logic                  FetchReq,
    input  logic [ADDR_WIDTH-1:0] FetchAddress,
    output logic                  FetchAck,
    output logic [DATA_WIDTH-1:0] FetchData,
    output logic                  FetchError,
    input  logic                  LsReq,
    input  logic                  LsWrite,
    input  logic [ADDR_WIDTH-1:0] LsAddress,
    input  logic [DATA_WIDTH-1:0] LsWriteData,
    output logic                  LsAck,
    output logic [DATA_WIDTH-1:0] LsReadData,
    output logic                  LsError,
    output logic [ADDR_WIDTH-1:0] AddressBus,
    input  logic [DATA_WIDTH-1:0] DataReadBus,
    output logic [DATA_WIDTH-1:0] DataWriteBus,
    output logic                  ReadAssert,
    output logic                  WriteAssert,
    input  logic                  ReadOK,
    input  logic                  WriteOK,
    output logic                  Busy
);

    arbState_t             state, stateNext;
    logic                  lastGrant, lastGrantNext;
    logic                  grantPort, grantPortNext;
    logic                  writeOp, writeOpNext;
    logic                  fetchWins, reqWrite;
    logic [ADDR_WIDTH-1:0] reqAddress, addressNext;
    logic [DATA_WIDTH-1:0] writeDataNext, resultData, fetchDataNext, lsReadDataNext;
    logic                  resultError, complete, timedOut, finishing;
    logic                  fetchAckNext, fetchErrorNext, lsAckNext, lsErrorNext;
    logic                  readAssertNext, writeAssertNext, busyNext;

    // Only the OK matching the latched operation completes the transfer.
    assign complete = writeOp ? WriteOK : ReadOK;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) timeoutCounter (
        .CoreClock (CoreClock),
        .CoreResetN(CoreResetN),
        .clear     (state != BUSY),
        .enable    ((state == BUSY) && !complete),
        .expired_c (timedOut)
    );

    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        grantPortNext = grantPort;
        writeOpNext   = writeOp;
        addressNext   = AddressBus;
        writeDataNext = DataWriteBus;
        resultError   = 1'b0;
        resultData    = '0;

        // Fetch wins when alone, or on a tie when load/store went last.
        fetchWins  = FetchReq && (!LsReq || (lastGrant == PORT_LS));
        reqAddress = fetchWins ? FetchAddress : LsAddress;
        reqWrite   = !fetchWins && LsWrite;

        case (state)
            IDLE: begin
                if (FetchReq || LsReq) begin
                    grantPortNext = fetchWins ? PORT_FETCH : PORT_LS;
                    lastGrantNext = grantPortNext;
                    writeOpNext   = reqWrite;
                    if (reqAddress[1:0] != 2'b00) begin
                        stateNext   = DONE;
                        resultError = 1'b1;
                    end else begin
                        stateNext     = BUSY;
                        addressNext   = {2'b00, reqAddress[ADDR_WIDTH-1:2]};
                        writeDataNext = reqWrite ? LsWriteData : '0;
                    end
                end
            end
            BUSY: begin
                if (complete) begin
                    stateNext  = DONE;
                    resultData = writeOp ? '0 : DataReadBus;
                end else if (timedOut) begin
                    stateNext   = DONE;
                    resultError = 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // Bus is only driven while a transfer is in flight.
        if (stateNext != BUSY) begin
            addressNext   = '0;
            writeDataNext = '0;
        end

        readAssertNext  = (stateNext == BUSY) && !writeOpNext;
        writeAssertNext = (stateNext == BUSY) && writeOpNext;
        busyNext        = (stateNext != IDLE);
        finishing       = (stateNext == DONE);
        fetchAckNext    = finishing && (grantPortNext == PORT_FETCH);
        lsAckNext       = finishing && (grantPortNext == PORT_LS);
        fetchErrorNext  = fetchAckNext && resultError;
        lsErrorNext     = lsAckNext && resultError;
        fetchDataNext   = fetchAckNext ? resultData : FetchData;
        lsReadDataNext  = lsAckNext ? resultData : LsReadData;
    end

    always_ff @(posedge CoreClock) begin
        if (!CoreResetN) begin
            state        <= IDLE;
            lastGrant    <= PORT_LS;
            grantPort    <= PORT_FETCH;
            writeOp      <= 1'b0;
            AddressBus   <= '0;
            DataWriteBus <= '0;
            ReadAssert   <= 1'b0;
            WriteAssert  <= 1'b0;
            Busy         <= 1'b0;
            FetchAck     <= 1'b0;
            FetchError   <= 1'b0;
            FetchData    <= '0;
            LsAck        <= 1'b0;
            LsError      <= 1'b0;
            LsReadData   <= '0;
        end else begin
            state        <= stateNext;
            lastGrant    <= lastGrantNext;
            grantPort    <= grantPortNext;
            writeOp      <= writeOpNext;
            AddressBus   <= addressNext;
            DataWriteBus <= writeDataNext;
            ReadAssert   <= readAssertNext;
            WriteAssert  <= writeAssertNext;
            Busy         <= busyNext;
            FetchAck     <= fetchAckNext;
            FetchError   <= fetchErrorNext;
            FetchData    <= fetchDataNext;
            LsAck        <= lsAckNext;
            LsError      <= lsErrorNext;
            LsReadData   <= lsReadDataNext;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with a transaction-level reference model.
module tb_memory_bus_arbiter;

    localparam int TO = 4;

    logic        CoreClock = 1'b0;
    logic        CoreResetN = 1'b0;
    logic        FetchReq = 1'b0, LsReq = 1'b0, LsWrite = 1'b0;
    logic [31:0] FetchAddress = '0, LsAddress = '0, LsWriteData = '0, DataReadBus = '0;
    logic        ReadOK = 1'b0, WriteOK = 1'b0;
    logic        FetchAck, FetchError, LsAck, LsError, ReadAssert, WriteAssert, Busy;
    logic [31:0] FetchData, LsReadData, AddressBus, DataWriteBus;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    memory_bus_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)
    ) dut (
        .CoreClock(CoreClock), .CoreResetN(CoreResetN),
        .FetchReq(FetchReq), .FetchAddress(FetchAddress), .FetchAck(FetchAck),
        .FetchData(FetchData), .FetchError(FetchError),
        .LsReq(LsReq), .LsWrite(LsWrite), .LsAddress(LsAddress), .LsWriteData(LsWriteData),
        .LsAck(LsAck), .LsReadData(LsReadData), .LsError(LsError),
        .AddressBus(AddressBus), .DataReadBus(DataReadBus), .DataWriteBus(DataWriteBus),
        .ReadAssert(ReadAssert), .WriteAssert(WriteAssert),
        .ReadOK(ReadOK), .WriteOK(WriteOK), .Busy(Busy)
    );

    always #5 CoreClock = ~CoreClock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got 0x%08h expected 0x%08h", name, cyc, got, exp);
        end
    endtask

    // Reference model: one transaction record, aged per cycle, then one ack cycle.
    logic        mRrLast = 1'b1, mActive = 1'b0, mAckNow = 1'b0, mWrite = 1'b0;
    logic        mPort = 1'b0, mErr = 1'b0, mDataChk = 1'b0;
    int          mAge = 0;
    logic [31:0] mWord = '0, mWData = '0, eFetchData = '0, eLsData = '0;

    always @(posedge CoreClock) begin : model
        logic        finish;
        logic        misaligned;
        logic [31:0] result;
        logic [31:0] addr;
        cyc++;
        finish = 1'b0; misaligned = 1'b0; result = '0; addr = '0;
        if (!CoreResetN) begin
            mActive = 1'b0; mAckNow = 1'b0; mRrLast = 1'b1;
            eFetchData = '0; eLsData = '0;
        end else if (mAckNow) begin
            mAckNow = 1'b0;
        end else if (mActive) begin
            mAge++;
            if (mWrite ? WriteOK : ReadOK) begin
                finish = 1'b1; mErr = 1'b0;
                result = mWrite ? 32'h0 : DataReadBus;
            end else if (mAge == TO) begin
                finish = 1'b1; mErr = 1'b1;
            end
        end else if (FetchReq || LsReq) begin
            mPort   = (FetchReq && LsReq) ? !mRrLast : LsReq;
            mRrLast = mPort;
            addr    = mPort ? LsAddress : FetchAddress;
            mWrite  = mPort && LsWrite;
            if (addr % 4 != 0) begin
                finish = 1'b1; misaligned = 1'b1; mErr = 1'b1;
            end else begin
                mActive = 1'b1; mAge = 0;
                mWord   = addr / 4;
                mWData  = mWrite ? LsWriteData : 32'h0;
            end
        end
        if (finish) begin
            mActive  = 1'b0;
            mAckNow  = 1'b1;
            mDataChk = !misaligned && (!mWrite || mErr);
            if (mDataChk) begin
                if (mPort) eLsData = result;
                else       eFetchData = result;
            end
        end
    end

    always @(negedge CoreClock) begin
        if (cyc > 0) begin
            chk("FetchAck",    32'(FetchAck),    32'(mAckNow && !mPort));
            chk("FetchError",  32'(FetchError),  32'(mAckNow && !mPort && mErr));
            chk("LsAck",       32'(LsAck),       32'(mAckNow && mPort));
            chk("LsError",     32'(LsError),     32'(mAckNow && mPort && mErr));
            chk("ReadAssert",  32'(ReadAssert),  32'(mActive && !mWrite));
            chk("WriteAssert", 32'(WriteAssert), 32'(mActive && mWrite));
            chk("Busy",        32'(Busy),        32'(mActive || mAckNow));
            if (mActive)       chk("AddressBus", AddressBus, mWord);
            else if (!mAckNow) chk("AddressBusIdle", AddressBus, 32'h0);
            if (mActive && mWrite) chk("DataWriteBus", DataWriteBus, mWData);
            else if (!mAckNow)     chk("DataWriteBusIdle", DataWriteBus, 32'h0);
            if (mAckNow && mDataChk) begin
                if (mPort) chk("LsReadData", LsReadData, eLsData);
                else       chk("FetchData", FetchData, eFetchData);
            end
        end
    end

    // Waits for a strobe, answers it after `delay` cycles; returns at the ack cycle.
    task automatic serveOne(input int delay, input logic [31:0] data, output int port);
        int n = 0;
        while (!(ReadAssert || WriteAssert) && n < 20) begin
            @(negedge CoreClock);
            n++;
        end
        if (n >= 20) chk("strobeWaitBound", 32'(n), 32'(0));
        repeat (delay) @(negedge CoreClock);
        ReadOK = ReadAssert; WriteOK = WriteAssert; DataReadBus = data;
        @(negedge CoreClock);
        ReadOK = 1'b0; WriteOK = 1'b0; DataReadBus = '0;
        port = FetchAck ? 0 : (LsAck ? 1 : 2);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
        $fatal(1);
    end

    initial begin : stim
        int port;
        int n;
        repeat (2) @(negedge CoreClock);
        chk("rstBusy", 32'(Busy), 32'h0);
        chk("rstAddr", AddressBus, 32'h0);
        chk("rstFetchData", FetchData, 32'h0);
        CoreResetN = 1'b1;

        // 1: fetch 0x100, ReadOK two cycles after the strobe rises
        FetchAddress = 32'h100; FetchReq = 1'b1;
        @(negedge CoreClock);
        chk("t1Read", 32'(ReadAssert), 32'h1);
        chk("t1Addr", AddressBus, 32'h40);
        repeat (2) @(negedge CoreClock);
        ReadOK = 1'b1; DataReadBus = 32'hDEADBEEF;
        @(negedge CoreClock);
        ReadOK = 1'b0; DataReadBus = '0;
        chk("t1Ack", 32'(FetchAck), 32'h1);
        chk("t1Data", FetchData, 32'hDEADBEEF);
        chk("t1Err", 32'(FetchError), 32'h0);
        FetchReq = 1'b0;
        @(negedge CoreClock);
        chk("t1Idle", 32'(Busy), 32'h0);

        // 2: store 0x12345678 to 0x8; requester inputs change after grant
        LsAddress = 32'h8; LsWriteData = 32'h12345678; LsWrite = 1'b1; LsReq = 1'b1;
        @(negedge CoreClock);
        chk("t2Write", 32'(WriteAssert), 32'h1);
        chk("t2Addr", AddressBus, 32'h2);
        chk("t2Data", DataWriteBus, 32'h12345678);
        LsWriteData = 32'hFFFF0000; LsAddress = 32'h44;
        @(negedge CoreClock);
        chk("t2DataHeld", DataWriteBus, 32'h12345678);
        WriteOK = 1'b1;
        @(negedge CoreClock);
        WriteOK = 1'b0;
        chk("t2Ack", 32'(LsAck), 32'h1);
        chk("t2Err", 32'(LsError), 32'h0);
        LsReq = 1'b0; LsWrite = 1'b0;
        @(negedge CoreClock);

        // 3: both ports held after reset alternate F, LS, F, LS
        CoreResetN = 1'b0;
        @(negedge CoreClock);
        CoreResetN = 1'b1;
        FetchAddress = 32'h200; LsAddress = 32'h300; LsWrite = 1'b0;
        FetchReq = 1'b1; LsReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serveOne(0, 32'hA0000000 + 32'(i), port);
            chk("t3Order", 32'(port), 32'(i % 2));
            chk("t3Data", (i % 2 == 1) ? LsReadData : FetchData, 32'hA0000000 + 32'(i));
        end
        FetchReq = 1'b0; LsReq = 1'b0;
        @(negedge CoreClock);

        // 4: misaligned load errors without a bus cycle
        LsAddress = 32'h6; LsReq = 1'b1;
        @(negedge CoreClock);
        chk("t4Ack", 32'(LsAck), 32'h1);
        chk("t4Err", 32'(LsError), 32'h1);
        LsReq = 1'b0;
        @(negedge CoreClock);

        // 5: fetch with no response times out after TO busy cycles
        FetchAddress = 32'h40; FetchReq = 1'b1;
        n = 0;
        do begin
            @(negedge CoreClock);
            n++;
        end while (!FetchAck && n < 20);
        chk("t5Latency", 32'(n), 32'd5);
        chk("t5Err", 32'(FetchError), 32'h1);
        chk("t5Data", FetchData, 32'h0);
        FetchReq = 1'b0;
        @(negedge CoreClock);
        chk("t5Idle", 32'(Busy), 32'h0);

        // 6a: stray WriteOK during a read is ignored
        FetchAddress = 32'h10; FetchReq = 1'b1;
        @(negedge CoreClock);
        @(negedge CoreClock);
        WriteOK = 1'b1;
        @(negedge CoreClock);
        WriteOK = 1'b0;
        chk("t6StillRead", 32'(ReadAssert), 32'h1);
        chk("t6NoAck", 32'(FetchAck), 32'h0);
        ReadOK = 1'b1; DataReadBus = 32'hCAFEF00D;
        @(negedge CoreClock);
        ReadOK = 1'b0; DataReadBus = '0;
        chk("t6Ack", 32'(FetchAck), 32'h1);
        chk("t6Data", FetchData, 32'hCAFEF00D);
        FetchReq = 1'b0;
        @(negedge CoreClock);

        // 6b: reset during a store aborts it silently
        LsAddress = 32'h20; LsWriteData = 32'h55; LsWrite = 1'b1; LsReq = 1'b1;
        @(negedge CoreClock);
        chk("t6bWrite", 32'(WriteAssert), 32'h1);
        @(negedge CoreClock);
        CoreResetN = 1'b0; LsReq = 1'b0; LsWrite = 1'b0;
        @(negedge CoreClock);
        chk("t6bStrobe", 32'(WriteAssert), 32'h0);
        chk("t6bAddr", AddressBus, 32'h0);
        chk("t6bWData", DataWriteBus, 32'h0);
        chk("t6bBusy", 32'(Busy), 32'h0);
        chk("t6bAck", 32'(LsAck), 32'h0);
        chk("t6bFetchData", FetchData, 32'h0);
        CoreResetN = 1'b1;
        repeat (3) @(negedge CoreClock);
        chk("t6bNoLateAck", 32'(LsAck), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
